// File: rtl/rv32i_mc_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with bus wait-state timeout.
// Outputs are Moore-decoded from state and IR; ir_write, retire and the transitions out of MEM are qualified by ready.
module rv32i_mc_sequencer #(
    parameter int TIMEOUT_W       = 6,
    parameter int TIMEOUT_EN      = 1,
    parameter int CNT_W           = 32,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pcsel,
    output logic             alusrc,
    output logic             alua_pc,
    output logic [3:0]       alucontrol,
    output logic             regwrite,
    output logic [1:0]       wbsel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       cause
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = WAIT_MAX - 1'b1;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]     instret_q, instret_d;
    logic [1:0]           cause_q, cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];

    logic is_load, is_store, is_op, is_opimm, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_op     = (opcode == 7'b0110011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);

    logic illegal;
    assign illegal = !(is_load || is_store || is_op || is_opimm || is_branch ||
                       is_jal || is_jalr || is_lui || is_auipc) ||
                     (is_branch && (funct3 == 3'b010 || funct3 == 3'b011));

    logic [3:0] alu_op;
    logic       br_taken;

    always_comb begin
        alu_op = ALU_ADD;
        if (is_op || is_opimm) begin
            case (funct3)
                3'b000:  alu_op = (is_op && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end else if (is_lui) begin
            alu_op = ALU_PASSB;
        end else if (is_branch) begin
            alu_op = ALU_SUB;
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pcsel      = 2'd0;
        alusrc     = 1'b0;
        alua_pc    = 1'b0;
        alucontrol = ALU_ADD;
        regwrite   = 1'b0;
        wbsel      = 2'd0;
        retire     = 1'b0;

        // ALU controls stay asserted through MEM/WB so an unlatched result remains stable.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alucontrol = alu_op;
            alusrc     = is_opimm || is_load || is_store || is_jalr || is_lui || is_auipc;
            alua_pc    = is_auipc || is_jal;
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (TIMEOUT_EN != 0 && wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    cause_d = 2'd2;
                end else begin
                    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    if (HALT_ON_ILLEGAL != 0) begin
                        state_d = S_HALT;
                        cause_d = 2'd1;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else begin
                    pc_write = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_write = br_taken;
                    pcsel    = br_taken ? 2'd1 : 2'd0;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_jal) begin
                    pc_write = 1'b1;
                    pcsel    = 2'd1;
                    state_d  = S_WB;
                end else if (is_jalr) begin
                    pc_write = 1'b1;
                    pcsel    = 2'd2;
                    state_d  = S_WB;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (TIMEOUT_EN != 0 && wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    cause_d = 2'd3;
                end else begin
                    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                wbsel    = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase

        instret_d = retire ? instret_q + 1'b1 : instret_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            instret_q <= '0;
            cause_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
        end
    end

    assign instret = instret_q;
    assign halted  = (state_q == S_HALT);
    assign cause   = cause_q;

endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// Directed bench for rv32i_mc_sequencer: instance a halts on illegal, instance b skips and has a 2-bit instret.
module tb_rv32i_mc_sequencer;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;   // addi x1,x0,5
    localparam logic [31:0] I_LW   = 32'h0000_a103;   // lw   x2,0(x1)
    localparam logic [31:0] I_BNE  = 32'h0020_9463;   // bne  x1,x2,+8
    localparam logic [31:0] I_SW   = 32'h0020_a223;   // sw   x2,4(x1)
    localparam logic [31:0] I_ILL  = 32'h0000_007f;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;

    logic        a_imem_req, a_dmem_req, a_dmem_we, a_ir_write, a_pc_write, a_alusrc, a_alua_pc;
    logic        a_regwrite, a_retire, a_halted;
    logic [1:0]  a_pcsel, a_wbsel, a_cause;
    logic [3:0]  a_alucontrol;
    logic [31:0] a_instret;

    logic        b_imem_req, b_dmem_req, b_dmem_we, b_ir_write, b_pc_write, b_alusrc, b_alua_pc;
    logic        b_regwrite, b_retire, b_halted;
    logic [1:0]  b_pcsel, b_wbsel, b_cause;
    logic [3:0]  b_alucontrol;
    logic [1:0]  b_instret;

    int total = 0;
    int bad   = 0;
    int n;
    int cyc;

    always #5 clk = ~clk;

    rv32i_mc_sequencer #(.TIMEOUT_W(3), .TIMEOUT_EN(1), .CNT_W(32), .HALT_ON_ILLEGAL(1)) dut_a (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
        .imem_req(a_imem_req), .imem_ready(imem_ready),
        .dmem_req(a_dmem_req), .dmem_we(a_dmem_we), .dmem_ready(dmem_ready),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .pcsel(a_pcsel),
        .alusrc(a_alusrc), .alua_pc(a_alua_pc), .alucontrol(a_alucontrol),
        .regwrite(a_regwrite), .wbsel(a_wbsel), .retire(a_retire),
        .instret(a_instret), .halted(a_halted), .cause(a_cause)
    );

    rv32i_mc_sequencer #(.TIMEOUT_W(3), .TIMEOUT_EN(1), .CNT_W(2), .HALT_ON_ILLEGAL(0)) dut_b (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
        .imem_req(b_imem_req), .imem_ready(imem_ready),
        .dmem_req(b_dmem_req), .dmem_we(b_dmem_we), .dmem_ready(dmem_ready),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .pcsel(b_pcsel),
        .alusrc(b_alusrc), .alua_pc(b_alua_pc), .alucontrol(b_alucontrol),
        .regwrite(b_regwrite), .wbsel(b_wbsel), .retire(b_retire),
        .instret(b_instret), .halted(b_halted), .cause(b_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_instret", a_instret, 0);
        chk("rst_halted", {31'd0, a_halted}, 0);
        chk("rst_cause", {30'd0, a_cause}, 0);
        chk("idle_imem_req", {31'd0, a_imem_req}, 0);
        chk("rst_retire", {31'd0, a_retire}, 0);

        // ADDI with immediate fetch
        instr = I_ADDI;
        tick();
        chk("addi_fetch_req", {31'd0, a_imem_req}, 1);
        imem_ready = 1'b1;
        #1;
        chk("addi_ir_write", {31'd0, a_ir_write}, 1);
        tick();
        imem_ready = 1'b0;
        #1;
        chk("addi_dec_pcw", {31'd0, a_pc_write}, 1);
        chk("addi_dec_pcsel", {30'd0, a_pcsel}, 0);
        chk("addi_dec_req", {31'd0, a_imem_req}, 0);
        tick();
        chk("addi_ex_alu", {28'd0, a_alucontrol}, 0);
        chk("addi_ex_alusrc", {31'd0, a_alusrc}, 1);
        chk("addi_ex_regwr", {31'd0, a_regwrite}, 0);
        tick();
        chk("addi_wb_regwr", {31'd0, a_regwrite}, 1);
        chk("addi_wb_wbsel", {30'd0, a_wbsel}, 0);
        chk("addi_wb_retire", {31'd0, a_retire}, 1);
        tick();
        chk("addi_instret", a_instret, 1);
        chk("addi_fetch_again", {31'd0, a_imem_req}, 1);

        // LW with three dmem wait states
        instr = I_LW;
        cyc = 1;
        imem_ready = 1'b1;
        tick(); cyc++;
        imem_ready = 1'b0;
        tick(); cyc++;
        chk("lw_ex_alusrc", {31'd0, a_alusrc}, 1);
        tick(); cyc++;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1'b1;
            #1;
            if (a_dmem_req && !a_dmem_we) n++;
            tick(); cyc++;
        end
        dmem_ready = 1'b0;
        #1;
        chk("lw_dmem_req_cycles", n, 4);
        chk("lw_wb_wbsel", {30'd0, a_wbsel}, 1);
        chk("lw_wb_retire", {31'd0, a_retire}, 1);
        chk("lw_latency", cyc, 8);
        tick();
        chk("lw_instret", a_instret, 2);

        // BNE taken, then not taken
        instr = I_BNE;
        zero = 1'b0;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        #1;
        chk("bne_dec_pcw", {31'd0, a_pc_write}, 1);
        tick();
        chk("bne_t_pcw", {31'd0, a_pc_write}, 1);
        chk("bne_t_pcsel", {30'd0, a_pcsel}, 1);
        chk("bne_t_alu", {28'd0, a_alucontrol}, 1);
        chk("bne_t_retire", {31'd0, a_retire}, 1);
        tick();
        zero = 1'b1;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        chk("bne_nt_pcw", {31'd0, a_pc_write}, 0);
        chk("bne_nt_retire", {31'd0, a_retire}, 1);
        tick();
        chk("bne_instret", a_instret, 4);

        // Fetch timeout after seven wait cycles
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (a_imem_req) n++;
            tick();
        end
        chk("to_req_cycles", n, 7);
        chk("to_halted", {31'd0, a_halted}, 1);
        chk("to_cause", {30'd0, a_cause}, 2);
        chk("to_req_off", {31'd0, a_imem_req}, 0);
        imem_ready = 1'b1;
        #1;
        chk("halt_no_irw", {31'd0, a_ir_write}, 0);
        tick();
        chk("halt_sticky", {31'd0, a_halted}, 1);
        imem_ready = 1'b0;

        // Ready on the seventh wait cycle wins over the timeout
        do_reset();
        instr = I_ADDI;
        tick();
        for (int i = 0; i < 6; i++) tick();
        imem_ready = 1'b1;
        #1;
        chk("late_ir_write", {31'd0, a_ir_write}, 1);
        tick();
        imem_ready = 1'b0;
        #1;
        chk("late_not_halted", {31'd0, a_halted}, 0);
        chk("late_dec_pcw", {31'd0, a_pc_write}, 1);
        tick();
        tick();
        tick();
        chk("late_instret", a_instret, 1);

        // Illegal opcode: a halts, b skips
        instr = I_ILL;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        #1;
        chk("ill_b_pcw", {31'd0, b_pc_write}, 1);
        chk("ill_b_pcsel", {30'd0, b_pcsel}, 0);
        chk("ill_b_retire", {31'd0, b_retire}, 1);
        chk("ill_b_regwr", {31'd0, b_regwrite}, 0);
        chk("ill_a_retire", {31'd0, a_retire}, 0);
        tick();
        chk("ill_a_halted", {31'd0, a_halted}, 1);
        chk("ill_a_cause", {30'd0, a_cause}, 1);
        chk("ill_a_instret", a_instret, 1);
        chk("ill_b_fetch", {31'd0, b_imem_req}, 1);
        chk("ill_b_instret", {30'd0, b_instret}, 2);

        // instret wrap on the 2-bit instance
        imem_ready = 1'b1;
        tick();
        tick();
        chk("wrap_b_3", {30'd0, b_instret}, 3);
        tick();
        tick();
        chk("wrap_b_0", {30'd0, b_instret}, 0);
        imem_ready = 1'b0;

        // Reset during a pending SW
        do_reset();
        instr = I_SW;
        tick();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        chk("sw_dmem_req", {31'd0, a_dmem_req}, 1);
        chk("sw_dmem_we", {31'd0, a_dmem_we}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("sw_rst_req_drop", {31'd0, a_dmem_req}, 0);
        chk("sw_rst_retire", {31'd0, a_retire}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("sw_rst_instret", a_instret, 0);
        chk("sw_rst_idle", {31'd0, a_imem_req}, 0);
        tick();
        chk("sw_rst_fetch", {31'd0, a_imem_req}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_mc_sequencer.md
Name: rv32i_mc_sequencer

Overview:
- Multi-cycle control sequencer for the next-generation RV32I core top. It replaces the single-cycle controller with a state machine that steps each instruction through fetch, decode, execute, memory and writeback.
- Talks to instruction and data memory over req/ready handshakes with wait states and a bus timeout.
- Drives datapath enables and selects, ALU op, retire pulse and a retired-instruction counter.
- Halts on illegal opcodes or bus errors.

Parameters:
- TIMEOUT_W, 6, width of the wait counter; a bus error is raised after 2^TIMEOUT_W-1 wait cycles.
- TIMEOUT_EN, 1, 0 disables the bus timeout (wait forever).
- CNT_W, 32, width of the instret counter.
- HALT_ON_ILLEGAL, 1, 1 halts on an illegal instruction; 0 skips it (pc+4, no writeback).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- instr  in  32  IR contents from the datapath, valid from DECODE onward.
- zero, lt, ltu  in  1 each  datapath compare flags, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid and accepted this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store when 1, load when 0 (qualified by dmem_req).
- dmem_ready  in  1  data access completes this cycle.
- ir_write  out  1  latch instr into IR, and the current pc into oldpc.
- pc_write  out  1  update pc.
- pcsel  out  2  0=pc+4, 1=oldpc+imm, 2=ALU result (JALR, bit0 cleared by datapath).
- alusrc  out  1  0=rs2, 1=imm.
- alua_pc  out  1  ALU A operand = oldpc (AUIPC/JAL).
- alucontrol  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- regwrite  out  1  register file write enable.
- wbsel  out  2  0=ALU, 1=readdata, 2=oldpc+4.
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
- instret  out  CNT_W  retired-instruction count; wraps to 0 at max.
- halted  out  1  sticky halt indicator.
- cause  out  2  0 none, 1 illegal, 2 imem timeout, 3 dmem timeout.

Behaviour:
- Reset (async, reset==0):
  - State goes to IDLE.
  - All outputs are 0, including instret, halted and cause.
- Outputs are Moore-decoded from the state plus the IR, except the ready-qualified strobes noted below.
- IDLE: goes to FETCH on the next clk.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE:
  - Legal opcodes: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Legal: pc_write=1 with pcsel=0, then go to EXEC.
  - Illegal opcode, or BRANCH with funct3 010/011:
    - HALT_ON_ILLEGAL=1: go to HALT, cause=1.
    - HALT_ON_ILLEGAL=0: pc_write with pcsel=0, retire=1, go to FETCH.
- EXEC, by instruction class:
  - OP/OP-IMM: ALU op from funct3/funct7[5]; SUB only for OP with funct7[5]=1; SRA when funct7[5]=1 on shift-right. Go to WB.
  - LUI: PASSB. Go to WB.
  - AUIPC: alua_pc=1, ADD. Go to WB.
  - LOAD/STORE: ADD, alusrc=1. Go to MEM.
  - BRANCH:
    - SUB compare; taken = BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu.
    - Taken: pc_write=1, pcsel=1.
    - retire=1, go to FETCH.
  - JAL: pc_write=1, pcsel=1. Go to WB.
  - JALR: ADD, alusrc=1, pc_write=1, pcsel=2. Go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - On dmem_ready: STORE retires (retire=1) and goes to FETCH; LOAD goes to WB.
  - Request is held stable until ready.
- WB:
  - regwrite=1; wbsel=1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - retire=1, go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on every ready.
  - With TIMEOUT_EN=1, reaching 2^TIMEOUT_W-1 without ready goes to HALT with cause=2 (FETCH) or 3 (MEM).
  - A ready arriving on the same cycle as the counter saturating wins: no error.
- HALT:
  - All requests and enables are 0; halted=1.
  - Leaves only on reset.
- instret increments on every retire cycle and wraps at 2^CNT_W-1 → 0.
- Reset asserted mid-FETCH/MEM drops the request asynchronously; nothing retires; the counter clears.
- No writes to x0 are filtered here; the register file ignores rd=0.

Test Plan:
- ADDI x1,x0,5 with imem_ready immediate → states IDLE,FETCH,DECODE,EXEC,WB; regwrite in WB with wbsel=0; retire once; instret=1.
- LW with dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; WB wbsel=1; 5+3 cycles from FETCH to retire.
- BNE with zero=0 then zero=1 → first: pc_write pulses in DECODE(pcsel 0) and EXEC(pcsel 1); second: EXEC pc_write=0; each retires in EXEC.
- TIMEOUT_W=3, imem_ready held 0 → HALT after 7 wait cycles, halted=1, cause=2; imem_req 0 afterwards; ready=1 on 7th cycle instead → normal DECODE.
- Opcode 1111111 with HALT_ON_ILLEGAL=1 → HALT, cause=1, instret unchanged; with 0 → pc+4, retire=1, no regwrite.
- reset=0 during MEM of SW with dmem_ready pending → dmem_req falls immediately; after release IDLE→FETCH; instret=0.
